// File: rtl/ram_1r1w.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, single clock.
// Define RAM_WR_FORWARD_EN for write-first collisions; the default build is read-first.
module ram_1r1w #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 180,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] w_addr,
    input  logic [WIDTH-1:0]     w_data,
    input  logic [ADDR_BITS-1:0] r_addr,
    output logic [WIDTH-1:0]     r_data
);

    generate
        if ((64'd1 << ADDR_BITS) < 64'(DEPTH)) begin : g_addr_chk
            $error("ram_1r1w: ADDR_BITS too small for DEPTH");
        end
    endgenerate

    // One extra bit so DEPTH == 2^ADDR_BITS still compares correctly.
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic w_ok;
    logic r_ok;

    assign w_ok = ({1'b0, w_addr} < DEPTH_W);
    assign r_ok = ({1'b0, r_addr} < DEPTH_W);

    // Storage kept in its own block with no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (!rst && we && w_ok)
            mem[w_addr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (r_ok) begin
`ifdef RAM_WR_FORWARD_EN
            if (we && w_ok && (w_addr == r_addr))
                r_data <= w_data;
            else
                r_data <= mem[r_addr];
`else
            r_data <= mem[r_addr];
`endif
        end else begin
            r_data <= '0;
        end
    end

endmodule

// File: tb/tb_ram_1r1w.sv
// Directed bench for ram_1r1w: write/read latency, collisions, bounds, reset, full sweep.
// Collision expectation follows RAM_WR_FORWARD_EN when the bench is built with it.
module tb_ram_1r1w;

    localparam int WIDTH     = 128;
    localparam int DEPTH     = 180;
    localparam int ADDR_BITS = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 we;
    logic [ADDR_BITS-1:0] w_addr;
    logic [WIDTH-1:0]     w_data;
    logic [ADDR_BITS-1:0] r_addr;
    logic [WIDTH-1:0]     r_data;

    int nvec = 0;
    int nerr = 0;

    ram_1r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_addr (r_addr),
        .r_data (r_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] exp);
        nvec++;
        assert (r_data === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, r_data, exp);
        end
    endtask

    task automatic wr(input int a, input logic [WIDTH-1:0] d);
        we     = 1'b1;
        w_addr = ADDR_BITS'(a);
        w_data = d;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; w_addr = '0; w_data = '0; r_addr = '0;

        tick();
        tick();
        chk("reset_rdata", '0);
        rst = 1'b0;

        // write then read, latency 1
        wr(5, 128'hAAAA);
        tick();
        we = 1'b0; r_addr = 8'd5;
        tick();
        chk("wr_rd_addr5", 128'hAAAA);

        // independent write and read at different addresses
        wr(10, 128'h5151);
        r_addr = 8'd5;
        tick();
        chk("indep_rd5", 128'hAAAA);
        we = 1'b0; r_addr = 8'd10;
        tick();
        chk("indep_rd10", 128'h5151);

        // same-address collision
        wr(3, 128'h11);
        tick();
        wr(3, 128'h22);
        r_addr = 8'd3;
        tick();
`ifdef RAM_WR_FORWARD_EN
        chk("collide_first", 128'h22);
`else
        chk("collide_first", 128'h11);
`endif
        we = 1'b0;
        tick();
        chk("collide_next", 128'h22);

        // bounds: out-of-range write must not alias onto 200-128=72
        wr(72, 128'h77);
        tick();
        wr(200, 128'hFF);
        tick();
        we = 1'b0; r_addr = 8'd200;
        tick();
        chk("oob_rd200", '0);
        r_addr = 8'd72;
        tick();
        chk("alias_rd72", 128'h77);
        r_addr = 8'd255;
        tick();
        chk("oob_rd255", '0);
        r_addr = 8'd179;
        wr(179, 128'hB3);
        tick();
        we = 1'b0;
        tick();
        chk("last_rd179", 128'hB3);

        // reset mid-operation drops the write and clears r_data only
        wr(0, 128'h1234);
        tick();
        we = 1'b0; r_addr = 8'd0;
        tick();
        chk("pre_rst_rd0", 128'h1234);
        rst = 1'b1;
        wr(0, 128'h9999);
        tick();
        chk("rst_rdata", '0);
        rst = 1'b0; we = 1'b0;
        tick();
        chk("post_rst_rd0", 128'h1234);

        // full sweep, back-to-back writes then back-to-back reads
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, WIDTH'(i * 3));
            tick();
        end
        we = 1'b0;
        r_addr = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            r_addr = ADDR_BITS'(i);
            tick();
            chk($sformatf("sweep_%0d", i), WIDTH'(i * 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
